// File: rtl/imem_uart_loader.sv
// Boot-time loader: receives a little-endian program image over UART and writes it word by word into instruction RAM.
// Optional feature: define IMEM_LOADER_CHKSUM_EN to build the running byte checksum on load_chksum.
module imem_uart_loader #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_imem,
  input  logic                  uart_rxd,
  output logic                  imem_wr,
  output logic [ADDR_WIDTH-3:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [3:0]            imem_byte_en,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  frame_err,
  output logic                  overflow,
  output logic [7:0]            load_chksum
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic             byte_valid, stop_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state  <= RX_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      rx_state  <= rx_state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    rx_state_nxt = rx_state;
    clk_cnt_nxt  = clk_cnt + 1'b1;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_reg;
    byte_valid   = 1'b0;
    stop_err     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        clk_cnt_nxt = '0;
        if (rx_prev && !rx_sync) begin
          rx_state_nxt = RX_START;
          bit_cnt_nxt  = '0;
        end
      end
      RX_START: begin
        // Mid start bit: a line already back high was only a glitch.
        if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
          clk_cnt_nxt  = '0;
          rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {rx_sync, shift_reg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_nxt  = '0;
          rx_state_nxt = RX_IDLE;
          byte_valid   = rx_sync;
          stop_err     = !rx_sync;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word packer and RAM write port
  // ---------------------------------------------------------------------------
  logic                  load_q, load_rise, load_fall, accept;
  logic [1:0]            byte_idx, idx_base;
  logic [ADDR_WIDTH-3:0] word_addr, addr_base;
  logic [31:0]           word_buf, buf_base;
  logic                  done_pending;

  assign load_rise = load_imem & ~load_q;
  assign load_fall = ~load_imem & load_q;
  assign accept    = byte_valid & load_imem;

  // A load starting in the same cycle a byte lands must see cleared packer state.
  assign idx_base  = load_rise ? '0 : byte_idx;
  assign addr_base = load_rise ? '0 : word_addr;
  assign buf_base  = load_rise ? '0 : word_buf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_q       <= 1'b0;
      byte_idx     <= '0;
      word_addr    <= '0;
      word_buf     <= '0;
      done_pending <= 1'b0;
      imem_wr      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      imem_byte_en <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      frame_err    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      load_q    <= load_imem;
      imem_wr   <= 1'b0;
      load_done <= 1'b0;
      byte_idx  <= idx_base;
      word_addr <= addr_base;
      word_buf  <= buf_base;

      if (stop_err)       frame_err <= 1'b1;
      else if (load_rise) frame_err <= 1'b0;

      if (load_rise) overflow <= 1'b0;

      if (done_pending) begin
        done_pending <= 1'b0;
        load_done    <= 1'b1;
        cpu_hold     <= 1'b0;
      end
      if (load_rise) cpu_hold <= 1'b1;

      if (accept) begin
        byte_idx <= idx_base + 2'd1;
        if (idx_base == 2'd3) begin
          imem_wr      <= 1'b1;
          imem_addr    <= addr_base;
          imem_wdata   <= {shift_reg, buf_base[23:0]};
          imem_byte_en <= 4'hF;
          word_buf     <= '0;
          word_addr    <= addr_base + 1'b1;
          if (addr_base == '1) overflow <= 1'b1;
        end else begin
          word_buf[{idx_base, 3'b000} +: 8] <= shift_reg;
        end
      end

      // The flush write takes one cycle, so load_done is deferred behind it.
      if (load_fall) begin
        if (byte_idx != 2'd0) begin
          imem_wr      <= 1'b1;
          imem_addr    <= word_addr;
          imem_wdata   <= word_buf;
          imem_byte_en <= (4'b0001 << byte_idx) - 4'b0001;
          byte_idx     <= '0;
          word_buf     <= '0;
          done_pending <= 1'b1;
        end else begin
          load_done <= 1'b1;
          cpu_hold  <= 1'b0;
        end
      end
    end
  end

`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0] chksum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         chksum_q <= '0;
    else if (load_rise) chksum_q <= accept ? shift_reg : 8'h00;
    else if (accept)    chksum_q <= chksum_q + shift_reg;
  end

  assign load_chksum = chksum_q;
`else
  assign load_chksum = 8'h00;
`endif

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: table-driven and randomized loads checked against an image-level model.
module tb_imem_uart_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << (AW - 2);
  localparam int CPB   = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_imem = 1'b0;
  logic          uart_rxd = 1'b1;
  logic          imem_wr;
  logic [AW-3:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [3:0]    imem_byte_en;
  logic          cpu_hold, load_done, frame_err, overflow;
  logic [7:0]    load_chksum;

  imem_uart_loader #(.CLK_FREQ(1000000), .BAUD(100000), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .load_imem(load_imem), .uart_rxd(uart_rxd),
    .imem_wr(imem_wr), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_byte_en(imem_byte_en), .cpu_hold(cpu_hold), .load_done(load_done),
    .frame_err(frame_err), .overflow(overflow), .load_chksum(load_chksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-3:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
    int            cyc;
  } wr_t;

  typedef struct {
    int pat;      // 0 random bytes, 1 the 13 05 00 00 image, 2 bytes 01..06
    int n;
    int bad;      // index of the byte sent with a low stop bit, -1 for none
    int exp_wr;
    bit exp_ferr;
    bit exp_ovf;
  } vec_t;

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  wr_t        wr_q[$];
  int         done_q[$];
  logic [7:0] tx_bytes[32];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_wr) wr_q.push_back('{imem_addr, imem_wdata, imem_byte_en, cyc});
    if (load_done) done_q.push_back(cyc);
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = stop;
    tick(CPB);
    uart_rxd = 1'b1;
    tick(2);
  endtask

  // Runs one complete load window and checks it against the image-level model.
  task automatic run_load(input int n, input int bad, input string tag, input bit glitch);
    logic [7:0]  acc[$];
    logic [7:0]  sum;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    int          nfull, rem, nexp, c;
    wr_q.delete();
    done_q.delete();
    load_imem = 1'b1;
    tick(3);
    check({tag, "_cpu_hold_on"}, 64'(cpu_hold), 64'd1);
    if (glitch) begin
      uart_rxd = 1'b0;
      tick(3);
      uart_rxd = 1'b1;
      tick(3 * CPB);
    end
    for (int i = 0; i < n; i++) begin
      send_byte(tx_bytes[i], i != bad);
      if (i != bad) acc.push_back(tx_bytes[i]);
    end
    tick(3);
    c = cyc;
    load_imem = 1'b0;
    tick(6);

    nfull = acc.size() / 4;
    rem   = acc.size() % 4;
    nexp  = nfull + ((rem != 0) ? 1 : 0);
    sum   = 8'h00;
    foreach (acc[i]) sum = sum + acc[i];

    check({tag, "_num_writes"}, 64'(wr_q.size()), 64'(nexp));
    for (int wi = 0; wi < nexp && wi < wr_q.size(); wi++) begin
      exp_data = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4 * wi + k < acc.size()) exp_data[8*k +: 8] = acc[4*wi+k];
      exp_be = (wi < nfull) ? 4'hF : 4'((1 << rem) - 1);
      check($sformatf("%s_w%0d_addr", tag, wi), 64'(wr_q[wi].addr), 64'(wi % DEPTH));
      check($sformatf("%s_w%0d_data", tag, wi), 64'(wr_q[wi].data), 64'(exp_data));
      check($sformatf("%s_w%0d_be", tag, wi), 64'(wr_q[wi].be), 64'(exp_be));
    end
    if (rem != 0 && wr_q.size() > 0)
      check({tag, "_flush_cycle"}, 64'(wr_q[wr_q.size()-1].cyc - c), 64'd1);
    check({tag, "_done_count"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0)
      check({tag, "_done_cycle"}, 64'(done_q[0] - c), (rem != 0) ? 64'd2 : 64'd1);
    check({tag, "_cpu_hold_off"}, 64'(cpu_hold), 64'd0);
    check({tag, "_frame_err"}, 64'(frame_err), (bad >= 0 && bad < n) ? 64'd1 : 64'd0);
    check({tag, "_overflow"}, 64'(overflow), (nfull >= DEPTH) ? 64'd1 : 64'd0);
`ifdef IMEM_LOADER_CHKSUM_EN
    check({tag, "_chksum"}, 64'(load_chksum), 64'(sum));
`else
    check({tag, "_chksum"}, 64'(load_chksum), 64'd0);
`endif
  endtask

  task automatic fill_bytes(input int pat);
    for (int i = 0; i < 32; i++) tx_bytes[i] = 8'($urandom);
    if (pat == 1) begin
      tx_bytes[0] = 8'h13; tx_bytes[1] = 8'h05; tx_bytes[2] = 8'h00; tx_bytes[3] = 8'h00;
    end else if (pat == 2) begin
      for (int i = 0; i < 6; i++) tx_bytes[i] = 8'(i + 1);
    end
  endtask

  initial begin
    vec_t vecs[9];
    int   n, bad;
    vecs[0] = '{1, 4, -1, 1, 1'b0, 1'b0};
    vecs[1] = '{2, 6, -1, 2, 1'b0, 1'b0};
    vecs[2] = '{0, 3, 1, 1, 1'b1, 1'b0};
    vecs[3] = '{0, 5, 4, 1, 1'b1, 1'b0};
    vecs[4] = '{0, 20, -1, 5, 1'b0, 1'b1};
    vecs[5] = '{0, 8, -1, 2, 1'b0, 1'b0};
    vecs[6] = '{0, 0, -1, 0, 1'b0, 1'b0};
    vecs[7] = '{0, 7, -1, 2, 1'b0, 1'b0};
    vecs[8] = '{0, 1, 0, 0, 1'b1, 1'b0};

    tick(3);
    check("rst_imem_wr", 64'(imem_wr), 64'd0);
    check("rst_outputs", 64'({imem_addr, imem_wdata, imem_byte_en, cpu_hold, load_done,
                              frame_err, overflow, load_chksum}), 64'd0);
    reset = 1'b1;
    tick(3);

    for (int v = 0; v < 9; v++) begin
      fill_bytes(vecs[v].pat);
      run_load(vecs[v].n, vecs[v].bad, $sformatf("vec%0d", v), 1'b0);
      check($sformatf("vec%0d_tbl_writes", v), 64'(wr_q.size()), 64'(vecs[v].exp_wr));
      check($sformatf("vec%0d_tbl_ferr", v), 64'(frame_err), 64'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_tbl_ovf", v), 64'(overflow), 64'(vecs[v].exp_ovf));
      tick(5);
    end

    // Glitch on the line: rejected alone, and the receiver still takes the next byte.
    fill_bytes(0);
    run_load(0, -1, "glitch_only", 1'b1);
    run_load(1, -1, "glitch_then_byte", 1'b1);

    // Reset in the middle of a word, with frame_err and cpu_hold set.
    fill_bytes(0);
    wr_q.delete();
    load_imem = 1'b1;
    tick(3);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h3C, 1'b1);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = 1'($urandom);
      tick(CPB);
    end
    check("pre_rst_frame_err", 64'(frame_err), 64'd1);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_outputs", 64'({imem_wr, imem_addr, imem_wdata, imem_byte_en, cpu_hold,
                                  load_done, frame_err, overflow, load_chksum}), 64'd0);
    uart_rxd = 1'b1;
    tick(4);
    check("mid_rst_no_write", 64'(wr_q.size()), 64'd0);
    reset = 1'b1;
    tick(2);
    run_load(4, -1, "restart", 1'b0);
    tick(5);

    for (int r = 0; r < 6; r++) begin
      fill_bytes(0);
      n   = int'($urandom_range(0, 12));
      bad = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_load(n, bad, $sformatf("rand%0d", r), 1'b0);
      tick(int'($urandom_range(1, 20)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
